// File: rtl/wb_slave_regfile.sv
// wb_slave_regfile: Wishbone classic slave with a byte-lane register file, programmable wait states and range check.
// Define WB_SLAVE_REGFILE_ERR_EN to terminate out-of-range accesses with wb_err_o instead of wb_ack_o.
module wb_slave_regfile #(
  parameter int          dw          = 32,
  parameter int          aw          = 32,
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        r_state;
  logic [7:0]    r_cnt;
  logic          r_hit;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [dw-1:0] r_wdat;
  logic [IW-1:0] r_idx;
  logic [dw-1:0] r_dat;
  logic          r_ack;
  logic          r_err;
  logic [dw-1:0] r_mem [DEPTH];
  logic [31:0]   w_off;
  logic          w_hit;
  logic          w_unused;
  assign w_off    = 32'(wb_adr_i) - BASE_ADDR;
  assign w_hit    = (w_off < 32'(DEPTH * 4)) && (w_off[1:0] == 2'b00);
  assign w_unused = &{1'b0, wb_cti_i, wb_bte_i};
  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = 1'b0;
  // WAIT always lasts WAIT_STATES+1 cycles, so the termination lands on edge N+1+WAIT_STATES
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdat  <= '0;
      r_idx   <= '0;
      r_dat   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: if (wb_cyc_i && wb_stb_i) begin
          r_hit   <= w_hit;
          r_idx   <= w_off[IW+1:2];
          r_we    <= wb_we_i;
          r_sel   <= wb_sel_i;
          r_wdat  <= wb_dat_i;
          r_cnt   <= 8'(WAIT_STATES);
          r_state <= WAIT;
        end
        WAIT: if (!wb_cyc_i) r_state <= IDLE;
        else if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        else begin
          r_state <= RESP;
          if (r_hit) begin
            r_ack <= 1'b1;
            if (r_we) begin
              for (int k = 0; k < 4; k++) if (r_sel[k]) r_mem[r_idx][8*k +: 8] <= r_wdat[8*k +: 8];
            end else r_dat <= r_mem[r_idx];
          end else begin
`ifdef WB_SLAVE_REGFILE_ERR_EN
            r_err <= 1'b1;
`else
            r_ack <= 1'b1;
            if (!r_we) r_dat <= '0;
`endif
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_slave_regfile.sv
// tb_wb_slave_regfile: directed and random Wishbone transfers checked against a byte-array model.
module tb_wb_slave_regfile;
  localparam int          W    = 3;
  localparam logic [31:0] BASE = 32'h100;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0, wdat = '0, rdat;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic        ack, err, rty;
  int          checks = 0, failures = 0;
  logic [7:0]  mem_b [64];
  logic [31:0] last_dat = '0;

  wb_slave_regfile #(.dw(32), .aw(32), .DEPTH(16), .BASE_ADDR(BASE), .WAIT_STATES(W)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(3'b000), .wb_bte_i(2'b00),
    .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mem_b[i] = 8'h00;
    last_dat = '0;
  endtask

  task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
    logic [31:0] off;
    bit hit, got;
    logic exp_ack, exp_err;
    int k;
    off = a - BASE;
    hit = (off < 64) && (off % 4 == 0);
    exp_ack = 1'b1;
    exp_err = 1'b0;
    if (hit) begin
      if (w) begin
        for (int b = 0; b < 4; b++) if (s[b]) mem_b[off + b] = d[8*b +: 8];
      end else last_dat = {mem_b[off+3], mem_b[off+2], mem_b[off+1], mem_b[off]};
    end else begin
`ifdef WB_SLAVE_REGFILE_ERR_EN
      exp_ack = 1'b0;
      exp_err = 1'b1;
`else
      if (!w) last_dat = '0;
`endif
    end
    @(negedge clk);
    adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    k = 0;
    got = 0;
    while (!got && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (ack || err) got = 1;
    end
    chk({tag, "_latency"}, k, W + 2);
    chk({tag, "_ack"}, {31'd0, ack}, {31'd0, exp_ack});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_dat"}, rdat, last_dat);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_single"}, {30'd0, ack, err}, 32'd0);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    xfer(tag, BASE + off, 32'h0, 4'hF, 1'b0);
    chk({tag, "_val"}, rdat, exp);
  endtask

  initial begin
    int acks;
    logic [31:0] a;
    clear_model();
    #2;
    chk("rst_out", {rdat[0], ack, err, rty}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_ack_err_rty", {29'd0, ack, err, rty}, 32'd0);
    chk("idle_dat", rdat, 32'd0);
    read_chk("rd0", 32'h0, 32'h0);
    read_chk("rd3c", 32'h3C, 32'h0);

    xfer("wr8", BASE + 32'h8, 32'hDEADBEEF, 4'hF, 1'b1);
    read_chk("rd8", 32'h8, 32'hDEADBEEF);
    xfer("wr4", BASE + 32'h4, 32'h11223344, 4'hF, 1'b1);
    xfer("wr4b", BASE + 32'h4, 32'h0000AA00, 4'h2, 1'b1);
    read_chk("rd4", 32'h4, 32'h1122AA44);

    xfer("miss_wr40", BASE + 32'h40, 32'hCAFEF00D, 4'hF, 1'b1);
    xfer("miss_rd2", BASE + 32'h2, 32'h0, 4'hF, 1'b0);
    xfer("miss_below", BASE - 32'h4, 32'h0, 4'hF, 1'b0);
    read_chk("rd0_after_miss", 32'h0, 32'h0);
    read_chk("rd8_after_miss", 32'h8, 32'hDEADBEEF);

    // abort: cyc drops while the slave is still waiting
    @(negedge clk);
    adr = BASE; wdat = 32'h55; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    acks = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ack || err) acks++;
    end
    chk("abort_no_term", acks, 0);
    read_chk("abort_rd0", 32'h0, 32'h0);

    // reset pulse mid-wait with a nonzero read value held on wb_dat_o
    read_chk("pre_rst_rd8", 32'h8, 32'hDEADBEEF);
    @(negedge clk);
    adr = BASE + 32'h8; wdat = 32'h77; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_dat", rdat, 32'd0);
    chk("midrst_ctl", {29'd0, ack, err, rty}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    read_chk("post_rst_rd8", 32'h8, 32'h0);
    xfer("post_rst_wr", BASE + 32'hC, 32'hA5A5_0F0F, 4'hF, 1'b1);
    read_chk("post_rst_rd", 32'hC, 32'hA5A5_0F0F);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: a = BASE + $urandom_range(0, 127);
        1: a = BASE - 32'($urandom_range(1, 16));
        default: a = BASE + 32'($urandom_range(0, 15) * 4);
      endcase
      xfer("rnd", a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 16; i++)
      read_chk("final", 32'(i * 4), {mem_b[i*4+3], mem_b[i*4+2], mem_b[i*4+1], mem_b[i*4]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
